// File: rtl/stoch_arith_core.sv
// Stochastic arithmetic core: LFSR-driven operand bitstreams, four selectable operators, ones counted over 2^LOG_LEN cycles.
// Result arrives 2^LOG_LEN cycles after accept and is held under res_valid until res_ready; in_ready is low outside IDLE.
module stoch_arith_core #(
  parameter int          W       = 9,
  parameter int          LOG_LEN = 17,
  parameter logic [30:0] SEED    = 31'd1349395
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [1:0]   mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [30:0]        lfsr;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [1:0]         mode_q;
  logic [LOG_LEN:0]   cnt;
  logic [LOG_LEN-1:0] smp;
  logic               d_q;

  logic               sa;
  logic               sb;
  logic               out_bit;
  logic [LOG_LEN:0]   cnt_next;
  logic               last;

  // A and B draw from disjoint LFSR slices so their streams are decorrelated
  assign sa = lfsr[W-1:0] < a_q;
  assign sb = lfsr[W+11:12] < b_q;

  always_comb begin
    out_bit = 1'b0;
    case (mode_q)
      2'd0:    out_bit = ~(sa ^ sb);
      2'd1:    out_bit = lfsr[30] ? sb : sa;
      2'd2:    out_bit = sa & sb;
      default: out_bit = ~(sa ^ d_q);
    endcase
  end

  assign cnt_next = cnt + {{LOG_LEN{1'b0}}, out_bit};
  assign last     = &smp;

  // rst_n is active-high here, inherited from the existing codebase
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      cnt    <= '0;
      smp    <= '0;
      d_q    <= 1'b0;
      result <= '0;
    end else begin
      lfsr <= {lfsr[29:0], lfsr[27] ^ lfsr[30]};
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= op_a;
            b_q    <= op_b;
            mode_q <= mode;
            cnt    <= '0;
            smp    <= '0;
            d_q    <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt_next;
          smp <= smp + {{(LOG_LEN-1){1'b0}}, 1'b1};
          d_q <= sa;
          if (last) begin
            // a full window of ones would overflow W bits, so clamp it
            result <= cnt_next[LOG_LEN] ? {W{1'b1}} : W'(cnt_next >> (LOG_LEN - W));
            state  <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign res_valid = (state == DONE);

endmodule
